// File: rtl/ir_receiver_decoder.sv
// ir_receiver_decoder
// Decodes carrier-modulated IR frames (start, car-select, four command bits)
// into a 4-bit drive command. Status and error count are exposed on a small
// 8-bit bus. A stale timer stops the car when frames stop arriving.
module ir_receiver_decoder #(
  parameter int         CLKS_PER_PERIOD = 2500,
  parameter int         START_LEN       = 191,
  parameter int         CARSEL_LEN      = 47,
  parameter int         ASSERT_LEN      = 47,
  parameter int         DEASSERT_LEN    = 22,
  parameter int         TOL             = 4,
  parameter int         GAP_MAX         = 40,
  parameter int         STALE_CLKS      = 25_000_000,
  parameter logic [7:0] BASE_ADDR       = 8'h91
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  inout  wire  [7:0] BUS_DATA,
  output logic [3:0] COMMAND,
  output logic       CMD_STROBE
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GAP1, S_CARSEL, S_GAP_B, S_BIT, S_DONE, S_ERROR
  } state_t;

  localparam int QUIET_W = $clog2(2 * CLKS_PER_PERIOD + 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(2 * CLKS_PER_PERIOD - 1);
  localparam int PER_W = (CLKS_PER_PERIOD > 1) ? $clog2(CLKS_PER_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CLKS_PER_PERIOD - 1);
  localparam int STALE_W = $clog2(STALE_CLKS + 1);
  localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CLKS - 1);
  localparam logic [STALE_W-1:0] STALE_END  = STALE_W'(STALE_CLKS);
  localparam logic [7:0] ERR_ADDR = BASE_ADDR + 8'd1;

  logic               ir_meta_r, ir_sync_r, ir_prev_r;
  logic               rise_s, env_rise_s, env_fall_s;
  logic               env_r;
  logic [QUIET_W-1:0] quiet_cnt_r;
  logic [7:0]         burst_cnt_r;
  logic [PER_W-1:0]   period_cnt_r;
  logic [7:0]         gap_cnt_r;
  state_t             state_r;
  logic [3:0]         shift_r;
  logic [1:0]         bit_cnt_r;
  logic [3:0]         command_r;
  logic               strobe_r;
  logic               valid_r;
  logic [7:0]         err_cnt_r;
  logic [STALE_W-1:0] stale_cnt_r;
  logic               gap_over_s, stale_expire_s;
  logic               rd_status_s, rd_err_s, wr_status_s, wr_err_s;
  logic [7:0]         rd_data_s;

  // True when a measured burst length lies within target +/- TOL
  function automatic logic len_ok(input logic [7:0] len, input int target);
    return (int'(len) >= target - TOL) && (int'(len) <= target + TOL);
  endfunction

  assign rise_s         = ir_sync_r & ~ir_prev_r;
  assign env_rise_s     = rise_s & ~env_r;
  assign env_fall_s     = env_r & ~rise_s & (quiet_cnt_r == QUIET_LAST);
  assign gap_over_s     = (int'(gap_cnt_r) > GAP_MAX);
  assign stale_expire_s = (stale_cnt_r == STALE_LAST);

  assign rd_status_s = RESET & ~BUS_WE & (BUS_ADDR == BASE_ADDR);
  assign rd_err_s    = RESET & ~BUS_WE & (BUS_ADDR == ERR_ADDR);
  assign wr_status_s = BUS_WE & (BUS_ADDR == BASE_ADDR);
  assign wr_err_s    = BUS_WE & (BUS_ADDR == ERR_ADDR);

  assign COMMAND    = command_r;
  assign CMD_STROBE = strobe_r;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ir_meta_r <= 1'b0;
      ir_sync_r <= 1'b0;
      ir_prev_r <= 1'b0;
    end else begin
      ir_meta_r <= IR_IN;
      ir_sync_r <= ir_meta_r;
      ir_prev_r <= ir_sync_r;
    end
  end

  // Envelope follower and burst length counter (carrier edges while envelope high)
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      env_r       <= 1'b0;
      quiet_cnt_r <= '0;
      burst_cnt_r <= 8'd0;
    end else if (rise_s) begin
      env_r       <= 1'b1;
      quiet_cnt_r <= '0;
      if (!env_r) begin
        burst_cnt_r <= 8'd1;
      end else if (burst_cnt_r != 8'hFF) begin
        burst_cnt_r <= burst_cnt_r + 8'd1;
      end
    end else if (env_r) begin
      if (quiet_cnt_r == QUIET_LAST) begin
        env_r       <= 1'b0;
        quiet_cnt_r <= '0;
      end else begin
        quiet_cnt_r <= quiet_cnt_r + QUIET_W'(1);
      end
    end
  end

  // Gap length in carrier periods, counted from the envelope fall
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      period_cnt_r <= '0;
      gap_cnt_r    <= 8'd0;
    end else if (env_r) begin
      period_cnt_r <= '0;
      gap_cnt_r    <= 8'd0;
    end else if (period_cnt_r == PER_LAST) begin
      period_cnt_r <= '0;
      if (gap_cnt_r != 8'hFF) begin
        gap_cnt_r <= gap_cnt_r + 8'd1;
      end
    end else begin
      period_cnt_r <= period_cnt_r + PER_W'(1);
    end
  end

  // Frame FSM with command, valid, error count and stale timer registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r     <= S_IDLE;
      shift_r     <= 4'd0;
      bit_cnt_r   <= 2'd0;
      command_r   <= 4'd0;
      strobe_r    <= 1'b0;
      valid_r     <= 1'b0;
      err_cnt_r   <= 8'd0;
      stale_cnt_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (env_rise_s) state_r <= S_START;
        end
        S_START: begin
          if (env_fall_s) state_r <= len_ok(burst_cnt_r, START_LEN) ? S_GAP1 : S_ERROR;
        end
        S_GAP1: begin
          if (gap_over_s)      state_r <= S_ERROR;
          else if (env_rise_s) state_r <= S_CARSEL;
        end
        S_CARSEL: begin
          bit_cnt_r <= 2'd0;
          if (env_fall_s) state_r <= len_ok(burst_cnt_r, CARSEL_LEN) ? S_GAP_B : S_ERROR;
        end
        S_GAP_B: begin
          if (gap_over_s)      state_r <= S_ERROR;
          else if (env_rise_s) state_r <= S_BIT;
        end
        S_BIT: begin
          if (env_fall_s) begin
            if (len_ok(burst_cnt_r, ASSERT_LEN) || len_ok(burst_cnt_r, DEASSERT_LEN)) begin
              // First bit received (right) ends up in bit 0 after four shifts
              shift_r   <= {len_ok(burst_cnt_r, ASSERT_LEN), shift_r[3:1]};
              bit_cnt_r <= bit_cnt_r + 2'd1;
              state_r   <= (bit_cnt_r == 2'd3) ? S_DONE : S_GAP_B;
            end else begin
              state_r <= S_ERROR;
            end
          end
        end
        S_DONE: begin
          state_r   <= S_IDLE;
          bit_cnt_r <= 2'd0;
        end
        S_ERROR: begin
          state_r   <= S_IDLE;
          shift_r   <= 4'd0;
          bit_cnt_r <= 2'd0;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase

      strobe_r <= (state_r == S_DONE);

      // A completed frame wins over both the stale timeout and a bus clear
      if (state_r == S_DONE) begin
        command_r   <= shift_r;
        valid_r     <= 1'b1;
        stale_cnt_r <= '0;
      end else begin
        if (stale_expire_s) command_r <= 4'd0;
        if (stale_expire_s || wr_status_s) valid_r <= 1'b0;
        if (stale_cnt_r != STALE_END) stale_cnt_r <= stale_cnt_r + STALE_W'(1);
      end

      // Clearing in the same cycle as an error leaves exactly that one error
      if (wr_err_s) begin
        err_cnt_r <= (state_r == S_ERROR) ? 8'd1 : 8'd0;
      end else if ((state_r == S_ERROR) && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  // Bus read data selected straight from the registers
  always_comb begin
    rd_data_s = 8'h00;
    if (rd_err_s) begin
      rd_data_s = err_cnt_r;
    end else begin
      rd_data_s = {3'b000, valid_r, command_r};
    end
  end

  assign BUS_DATA = (rd_status_s | rd_err_s) ? rd_data_s : 8'hzz;

endmodule

// File: tb/tb_ir_receiver_decoder.sv
// Bench for ir_receiver_decoder: synthetic carrier bursts, scoreboard of
// expected commands popped on CMD_STROBE, and bus register reads.
module tb_ir_receiver_decoder;

  localparam int         CPP    = 4;
  localparam int         STALE  = 20000;
  localparam logic [7:0] A_STAT = 8'h91;
  localparam logic [7:0] A_ERR  = 8'h92;
  localparam logic [7:0] A_IDLE = 8'h00;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       IR_IN = 1'b0;
  logic       BUS_WE = 1'b0;
  logic [7:0] BUS_ADDR = A_IDLE;
  wire  [7:0] BUS_DATA;
  logic [3:0] COMMAND;
  logic       CMD_STROBE;

  logic       tb_oe = 1'b0;
  logic [7:0] tb_val = 8'h00;
  assign BUS_DATA = tb_oe ? tb_val : 8'hzz;

  int         n_checks = 0;
  int         n_errors = 0;
  int         strobe_cnt = 0;
  int         frames_sent = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic [7:0] rd_val;

  ir_receiver_decoder #(
    .CLKS_PER_PERIOD(CPP),
    .STALE_CLKS     (STALE)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IR_IN     (IR_IN),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_WE    (BUS_WE),
    .BUS_DATA  (BUS_DATA),
    .COMMAND   (COMMAND),
    .CMD_STROBE(CMD_STROBE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding frame
  always @(negedge CLK) begin
    if (RESET && CMD_STROBE) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", {7'b0, CMD_STROBE}, 8'h00);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("command", {4'b0, COMMAND}, {4'b0, mon_exp});
      end
    end
  end

  // All tasks start and end on a falling clock edge
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic burst(input int n);
    repeat (n) begin
      IR_IN = 1'b1;
      repeat (CPP / 2) @(negedge CLK);
      IR_IN = 1'b0;
      repeat (CPP - CPP / 2) @(negedge CLK);
    end
  endtask

  task automatic gap(input int n);
    IR_IN = 1'b0;
    repeat (n * CPP) @(negedge CLK);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    tb_oe    = 1'b0;
    #1;
    d = BUS_DATA;
    @(negedge CLK);
    BUS_ADDR = A_IDLE;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic bus_write(input logic [7:0] a);
    BUS_ADDR = a;
    BUS_WE   = 1'b1;
    tb_oe    = 1'b1;
    tb_val   = 8'hFF;
    @(negedge CLK);
    BUS_WE   = 1'b0;
    tb_oe    = 1'b0;
    BUS_ADDR = A_IDLE;
  endtask

  // Bench holds the bus at 00; any DUT drive of nonzero data disturbs it
  task automatic hiz_probe(input string tag, input logic [7:0] a);
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    tb_val   = 8'h00;
    tb_oe    = 1'b1;
    #1;
    check_eq(tag, BUS_DATA, 8'h00);
    @(negedge CLK);
    tb_oe    = 1'b0;
    BUS_ADDR = A_IDLE;
  endtask

  // Full frame; the last bit's envelope fall puts the FSM in DONE exactly
  // CPP+3 falling edges after the burst ends (sync latency + 2*CPP quiet).
  // mode 1 reads status in the DONE cycle, mode 2 clears VALID in it.
  task automatic send_frame(input logic [3:0] cmd, input int mode, input logic [7:0] pre_stat);
    exp_q.push_back(cmd);
    frames_sent++;
    burst(191);
    gap(25);
    burst(47);
    for (int i = 0; i < 4; i++) begin
      gap(25);
      burst(cmd[i] ? 47 : 22);
    end
    idle(CPP + 3);
    case (mode)
      1: read_check("read_in_done", A_STAT, pre_stat);
      2: bus_write(A_STAT);
      default: ;
    endcase
    gap(30);
  endtask

  initial begin
    // Reset state
    RESET = 1'b0;
    idle(5);
    check_eq("reset_command", {4'b0, COMMAND}, 8'h00);
    check_eq("reset_strobe", {7'b0, CMD_STROBE}, 8'h00);
    hiz_probe("hiz_in_reset", A_STAT);
    RESET = 1'b1;
    idle(5);
    read_check("reset_status", A_STAT, 8'h00);
    read_check("reset_errcnt", A_ERR, 8'h00);

    // Nominal frame: right and forward asserted
    send_frame(4'b1001, 0, 8'h00);
    read_check("frame1_status", A_STAT, 8'h19);
    check_eq("frame1_strobes", 8'(strobe_cnt), 8'(frames_sent));

    // Short start burst rejected, command kept
    burst(180);
    gap(10);
    read_check("short_start_err", A_ERR, 8'h01);
    check_eq("short_start_cmd", {4'b0, COMMAND}, 8'h09);
    check_eq("short_start_strobes", 8'(strobe_cnt), 8'(frames_sent));

    // Unmapped addresses leave the bus floating
    hiz_probe("hiz_90", 8'h90);
    hiz_probe("hiz_93", 8'h93);
    hiz_probe("hiz_ff", 8'hFF);

    // Overlong gap after car-select
    burst(191);
    gap(25);
    burst(47);
    gap(60);
    read_check("long_gap_err", A_ERR, 8'h02);

    // Next frame decodes; a read in its DONE cycle sees the old status
    send_frame(4'b0110, 1, 8'h19);
    read_check("frame2_status", A_STAT, 8'h16);

    // VALID clear write, then a clear landing on DONE loses to the set
    bus_write(A_STAT);
    read_check("valid_cleared", A_STAT, 8'h06);
    send_frame(4'b1111, 2, 8'h00);
    read_check("done_beats_clear", A_STAT, 8'h1F);

    // Reset in the middle of the third bit burst
    exp_q.push_back(4'b0000);
    burst(191);
    gap(25);
    burst(47);
    gap(25);
    burst(47);
    gap(25);
    burst(22);
    gap(25);
    burst(20);
    RESET = 1'b0;
    void'(exp_q.pop_back());
    idle(4);
    check_eq("midreset_command", {4'b0, COMMAND}, 8'h00);
    check_eq("midreset_strobe", {7'b0, CMD_STROBE}, 8'h00);
    RESET = 1'b1;
    gap(10);
    read_check("midreset_status", A_STAT, 8'h00);
    read_check("midreset_errcnt", A_ERR, 8'h00);
    send_frame(4'b0101, 0, 8'h00);
    read_check("frame_after_reset", A_STAT, 8'h15);
    read_check("errcnt_after_reset", A_ERR, 8'h00);

    // Five bad frames, then a clear write in the same cycle as the next ERROR
    for (int k = 0; k < 5; k++) begin
      burst(100);
      gap(10);
    end
    read_check("errcnt_five", A_ERR, 8'h05);
    burst(180);
    idle(CPP + 3);
    bus_write(A_ERR);
    gap(10);
    read_check("err_clear_collide", A_ERR, 8'h01);
    check_eq("cmd_before_stale", {4'b0, COMMAND}, 8'h05);

    // Silence long enough for the stale timer to stop the car
    idle(STALE);
    check_eq("stale_command", {4'b0, COMMAND}, 8'h00);
    read_check("stale_status", A_STAT, 8'h00);
    read_check("stale_errcnt", A_ERR, 8'h01);

    check_eq("total_strobes", 8'(strobe_cnt), 8'(frames_sent));
    check_eq("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
